// File: rtl/fft_digit_reverse_reorder.sv
// Ping-pong reorder buffer: turns the radix-4 FFT's base-4 digit-reversed output stream into natural order.
// Optional feature macro REORDER_BACKPRESSURE_EN adds output_ready back-pressure and a sticky overflow flag.
module fft_digit_reverse_reorder #(
  parameter int WIDTH = 16,
  parameter int N     = 256
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             input_en,
  input  logic [WIDTH-1:0] input_real,
  input  logic [WIDTH-1:0] input_imag,
  output logic             output_en,
  output logic [WIDTH-1:0] output_real,
  output logic [WIDTH-1:0] output_imag
`ifdef REORDER_BACKPRESSURE_EN
  ,
  input  logic             output_ready,
  output logic             overflow
`endif
);

  localparam int A = $clog2(N);

  typedef enum logic {IDLE, READ} rd_state_t;

  logic [2*WIDTH-1:0] mem [2*N];
  logic [A-1:0]       wcnt;
  logic [A-1:0]       rcnt;
  logic               wbank;
  logic               rbank;
  logic [1:0]         full;
  logic [1:0]         full_set;
  logic [1:0]         full_clr;
  rd_state_t          state;
  logic               dropping;
  logic               out_ready;
  logic               issue;
  logic               pop;
  logic [1:0]         skid_cnt;
  logic [2*WIDTH-1:0] head;
  logic [2*WIDTH-1:0] tail;
  logic [2*WIDTH-1:0] rd_word;

  function automatic logic [A-1:0] drev(input logic [A-1:0] a);
    logic [A-1:0] r;
    r = '0;
    for (int i = 0; i < A/2; i++) r[2*i +: 2] = a[A-2-2*i +: 2];
    return r;
  endfunction

`ifdef REORDER_BACKPRESSURE_EN
  logic drop_frame;

  assign out_ready = output_ready;
  // The drop decision is taken on the first sample and held for the rest of the frame.
  assign dropping  = (wcnt == '0) ? full[wbank] : drop_frame;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      drop_frame <= 1'b0;
      overflow   <= 1'b0;
    end else if (input_en) begin
      drop_frame <= dropping;
      if (dropping) overflow <= 1'b1;
    end
  end
`else
  assign out_ready = 1'b1;
  assign dropping  = 1'b0;
`endif

  assign full_set = (input_en && !dropping && (&wcnt)) ? (wbank ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wcnt  <= '0;
      wbank <= 1'b0;
    end else if (input_en) begin
      wcnt <= wcnt + 1'b1;
      if ((&wcnt) && !dropping) wbank <= ~wbank;
    end
  end

  always_ff @(posedge clock) begin
    if (input_en && !dropping) mem[{wbank, drev(wcnt)}] <= {input_real, input_imag};
  end

  // IDLE issues address 0 in the same cycle it sees a full bank, keeping the latency at two cycles.
  assign issue    = ((state == READ) || full[rbank]) && (skid_cnt != 2'd2);
  assign full_clr = (issue && (&rcnt)) ? (rbank ? 2'b10 : 2'b01) : 2'b00;
  assign rd_word  = mem[{rbank, rcnt}];
  assign pop      = output_en && out_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) full <= 2'b00;
    else        full <= (full & ~full_clr) | full_set;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      rcnt  <= '0;
      rbank <= 1'b0;
    end else if (issue) begin
      if (&rcnt) begin
        rcnt  <= '0;
        rbank <= ~rbank;
        state <= full[~rbank] ? READ : IDLE;
      end else begin
        rcnt  <= rcnt + 1'b1;
        state <= READ;
      end
    end
  end

  // head is the registered output; tail absorbs the one read already in flight when the consumer stalls.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      skid_cnt  <= 2'd0;
      output_en <= 1'b0;
      head      <= '0;
      tail      <= '0;
    end else begin
      case ({pop, issue})
        2'b01: begin
          if (skid_cnt == 2'd0) head <= rd_word;
          else                  tail <= rd_word;
          skid_cnt  <= skid_cnt + 2'd1;
          output_en <= 1'b1;
        end
        2'b10: begin
          if (skid_cnt == 2'd2) head <= tail;
          skid_cnt  <= skid_cnt - 2'd1;
          output_en <= (skid_cnt == 2'd2);
        end
        2'b11: head <= rd_word;
        default: ;
      endcase
    end
  end

  assign output_real = head[2*WIDTH-1:WIDTH];
  assign output_imag = head[WIDTH-1:0];

endmodule
